// File: rtl/multi_btn_led_controller.sv
// Multi-channel button front end: synchroniser, debounce, press pulse and
// per-channel LED drive in one of four global modes (follow/toggle/blink/off).
module multi_btn_led_controller #(
    parameter int   CHANNELS     = 4,
    parameter int   DEBOUNCE     = 4,
    parameter int   BLINK_HALF   = 8,
    parameter logic ACTIVE_LEVEL = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] btn_in,
    input  logic [1:0]          mode,
    output logic [CHANNELS-1:0] btn_state,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] led_out
);

    localparam int DW = $clog2(DEBOUNCE);
    // A blink half-period of one cycle still needs a 1-bit counter to compile.
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    typedef enum logic [1:0] {
        MODE_FOLLOW = 2'b00,
        MODE_TOGGLE = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_OFF    = 2'b11
    } mode_t;

    mode_t mode_sel;
    assign mode_sel = mode_t'(mode);

    logic [CHANNELS-1:0] sync1_reg;
    logic [CHANNELS-1:0] sync2_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= {CHANNELS{~ACTIVE_LEVEL}};
            sync2_reg <= {CHANNELS{~ACTIVE_LEVEL}};
        end else begin
            sync1_reg <= btn_in;
            sync2_reg <= sync1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [DW-1:0] db_cnt_reg;
            logic [BW-1:0] blink_cnt_reg;
            logic          state_reg;
            logic          pulse_reg;
            logic          toggle_reg;
            logic          phase_reg;
            logic          led_reg;
            logic          pressed;
            logic          accept;
            logic          press;
            logic          led_next;

            assign pressed = (sync2_reg[gi] == ACTIVE_LEVEL);
            assign accept  = (pressed != state_reg) && (db_cnt_reg == DW'(DEBOUNCE - 1));
            assign press   = accept && pressed;

            always_comb begin
                led_next = 1'b0;
                unique case (mode_sel)
                    MODE_FOLLOW: led_next = state_reg;
                    MODE_TOGGLE: led_next = toggle_reg;
                    MODE_BLINK:  led_next = state_reg & phase_reg;
                    MODE_OFF:    led_next = 1'b0;
                    default:     led_next = 1'b0;
                endcase
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    db_cnt_reg    <= '0;
                    blink_cnt_reg <= '0;
                    state_reg     <= 1'b0;
                    pulse_reg     <= 1'b0;
                    toggle_reg    <= 1'b0;
                    phase_reg     <= 1'b0;
                    led_reg       <= 1'b0;
                end else begin
                    // Any return to the accepted level restarts the stability count.
                    if (pressed == state_reg) begin
                        db_cnt_reg <= '0;
                    end else if (accept) begin
                        state_reg  <= pressed;
                        db_cnt_reg <= '0;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + 1'b1;
                    end

                    pulse_reg <= press;

                    if (press && (mode_sel == MODE_TOGGLE)) begin
                        toggle_reg <= ~toggle_reg;
                    end

                    // Blink restarts in the lit phase on every new press.
                    if (press) begin
                        blink_cnt_reg <= '0;
                        phase_reg     <= 1'b1;
                    end else if (state_reg) begin
                        if (blink_cnt_reg == BW'(BLINK_HALF - 1)) begin
                            blink_cnt_reg <= '0;
                            phase_reg     <= ~phase_reg;
                        end else begin
                            blink_cnt_reg <= blink_cnt_reg + 1'b1;
                        end
                    end else begin
                        blink_cnt_reg <= '0;
                        phase_reg     <= 1'b0;
                    end

                    led_reg <= led_next;
                end
            end

            assign btn_state[gi]   = state_reg;
            assign press_pulse[gi] = pulse_reg;
            assign led_out[gi]     = led_reg;
        end
    endgenerate

endmodule

// File: tb/tb_multi_btn_led_controller.sv
// Bench for multi_btn_led_controller: an active-high and an active-low build
// run side by side against a cycle-level reference model plus literal checks.
module tb_multi_btn_led_controller;

    localparam int CH = 4;
    localparam int DB = 4;
    localparam int BH = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CH-1:0] btn = '0;
    logic [CH-1:0] btn_n;
    logic [1:0]    mode = 2'b00;
    logic [CH-1:0] st_p, pu_p, led_p;
    logic [CH-1:0] st_n, pu_n, led_n;

    assign btn_n = ~btn;

    multi_btn_led_controller #(
        .CHANNELS(CH), .DEBOUNCE(DB), .BLINK_HALF(BH), .ACTIVE_LEVEL(1'b1)
    ) dut_p (
        .clk(clk), .reset(reset), .btn_in(btn), .mode(mode),
        .btn_state(st_p), .press_pulse(pu_p), .led_out(led_p)
    );

    multi_btn_led_controller #(
        .CHANNELS(CH), .DEBOUNCE(DB), .BLINK_HALF(BH), .ACTIVE_LEVEL(1'b0)
    ) dut_n (
        .clk(clk), .reset(reset), .btn_in(btn_n), .mode(mode),
        .btn_state(st_n), .press_pulse(pu_n), .led_out(led_n)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model in terms of "pressed" samples, run lengths and time since press.
    bit m_s1[CH], m_s2[CH], m_state[CH], m_pulse[CH], m_tog[CH], m_blink[CH], m_led[CH];
    int m_run[CH], m_age[CH];

    function automatic bit m_phase(input int i);
        return m_blink[i] && (((m_age[i] / BH) % 2) == 0);
    endfunction

    always @(posedge clk) begin
        bit p, os, acc;
        for (int i = 0; i < CH; i++) begin
            if (reset) begin
                m_s1[i] = 0; m_s2[i] = 0; m_state[i] = 0; m_pulse[i] = 0;
                m_tog[i] = 0; m_blink[i] = 0; m_led[i] = 0; m_run[i] = 0; m_age[i] = 0;
            end else begin
                p  = m_s2[i];
                os = m_state[i];
                case (mode)
                    2'b00:   m_led[i] = os;
                    2'b01:   m_led[i] = m_tog[i];
                    2'b10:   m_led[i] = os & m_phase(i);
                    default: m_led[i] = 1'b0;
                endcase
                acc = 1'b0;
                if (p != os) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_state[i] = p;
                        m_run[i] = 0;
                        acc = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_pulse[i] = acc && p;
                if (m_pulse[i] && mode == 2'b01) m_tog[i] = ~m_tog[i];
                if (m_pulse[i]) begin
                    m_age[i] = 0; m_blink[i] = 1;
                end else if (os) begin
                    m_age[i]++;
                end else begin
                    m_age[i] = 0; m_blink[i] = 0;
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = btn[i];
            end
        end
    end

    logic [CH-1:0] e_st, e_pu, e_led;
    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < CH; i++) begin
                e_st[i] = m_state[i]; e_pu[i] = m_pulse[i]; e_led[i] = m_led[i];
            end
            chk("model_state_p", st_p, e_st);
            chk("model_pulse_p", pu_p, e_pu);
            chk("model_led_p", led_p, e_led);
            chk("model_state_n", st_n, e_st);
            chk("model_pulse_n", pu_n, e_pu);
            chk("model_led_n", led_n, e_led);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pcount, pidx;
        tick();
        checking = 1'b1;
        tick();
        reset = 1'b0;

        // Idle, then a reset in the middle of a ch0 debounce.
        repeat (20) tick();
        chk("idle_state", st_p, 0);
        chk("idle_pulse", pu_p, 0);
        chk("idle_led", led_p, 0);
        btn[0] = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        btn[0] = 1'b0;
        tick();
        reset = 1'b0;
        repeat (10) tick();
        chk("rst_mid_debounce", st_p, 0);

        // FOLLOW: clean press and release on ch0.
        btn[0] = 1'b1;
        repeat (5) tick();
        chk("follow_pre_accept", st_p, 4'b0000);
        tick();
        chk("follow_state", st_p, 4'b0001);
        chk("follow_pulse", pu_p, 4'b0001);
        chk("follow_led_lag", led_p, 4'b0000);
        tick();
        chk("follow_pulse_end", pu_p, 4'b0000);
        chk("follow_led", led_p, 4'b0001);
        btn[0] = 1'b0;
        repeat (6) tick();
        chk("release_state", st_p, 4'b0000);
        chk("release_no_pulse", pu_p, 4'b0000);
        chk("release_led_lag", led_p, 4'b0001);
        tick();
        chk("release_led", led_p, 4'b0000);

        // Bouncing ch1 for 30 cycles, then a steady hold.
        for (int seg = 0; seg < 10; seg++) begin
            btn[1] = (seg % 2 == 0);
            repeat (3) tick();
        end
        chk("bounce_state", st_p, 4'b0000);
        btn[1] = 1'b1;
        pcount = 0;
        pidx = -1;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (pu_p[1]) begin
                pcount++;
                pidx = t;
            end
        end
        chk("bounce_pulse_count", pcount, 1);
        chk("bounce_pulse_edge", pidx, 5);
        btn[1] = 1'b0;
        repeat (8) tick();

        // TOGGLE: three presses on ch2, then a mode round trip.
        mode = 2'b01;
        for (int k = 0; k < 3; k++) begin
            btn[2] = 1'b1;
            repeat (7) tick();
            chk("toggle_led", led_p[2], (k % 2 == 0));
            btn[2] = 1'b0;
            repeat (8) tick();
        end
        mode = 2'b00;
        repeat (3) tick();
        chk("toggle_follow_led", led_p[2], 0);
        mode = 2'b01;
        repeat (2) tick();
        chk("toggle_kept", led_p[2], 1);

        // BLINK: hold ch3 for 20 cycles.
        mode = 2'b10;
        btn[3] = 1'b1;
        repeat (6) tick();
        chk("blink_pulse", pu_p, 4'b1000);
        for (int j = 0; j < 12; j++) begin
            tick();
            chk("blink_pattern", led_p[3], ((j / 3) % 2 == 0));
        end
        repeat (2) tick();
        btn[3] = 1'b0;
        repeat (6) tick();
        chk("blink_release_state", st_p[3], 0);
        tick();
        chk("blink_release_led", led_p[3], 0);

        // OFF: simultaneous presses on every channel of both builds.
        mode = 2'b11;
        repeat (4) tick();
        btn = '1;
        repeat (6) tick();
        chk("all_state_p", st_p, 4'hF);
        chk("all_pulse_p", pu_p, 4'hF);
        chk("all_state_n", st_n, 4'hF);
        chk("all_pulse_n", pu_n, 4'hF);
        tick();
        chk("all_led_p", led_p, 4'h0);
        chk("all_led_n", led_n, 4'h0);
        chk("all_pulse_end", pu_p, 4'h0);
        btn = '0;
        repeat (8) tick();

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/multi_btn_led_controller.md
Name: multi_btn_led_controller

Overview:
- Parametrised successor to the single-button LED controller. Handles CHANNELS independent buttons.
- Per channel it performs:
  - 2-flop synchronisation
  - counter-based debounce with selectable button polarity
  - one-cycle press-pulse generation
  - LED drive in one of four global modes: follow, toggle, blink, off
- Sits between raw board buttons and LEDs. Also exports clean button levels and press pulses for other logic.

Parameters:
- CHANNELS, 4: number of independent button/LED channels (>=1).
- DEBOUNCE, 4: consecutive stable cycles needed to accept a new level (>=2).
- BLINK_HALF, 8: blink half-period in clk cycles (>=1).
- ACTIVE_LEVEL, 1'b1: raw btn_in level that means "pressed".

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- btn_in  in  CHANNELS  raw asynchronous button inputs
- mode  in  2  global LED mode, sampled every cycle: 00 FOLLOW, 01 TOGGLE, 10 BLINK, 11 OFF
- btn_state  out  CHANNELS  debounced level per channel, 1 = pressed, regardless of ACTIVE_LEVEL
- press_pulse  out  CHANNELS  one-cycle pulse on each accepted press
- led_out  out  CHANNELS  registered LED drive

Behaviour:
- Reset values (at next clk edge with reset=1):
  - sync flops = ~ACTIVE_LEVEL
  - debounce counters = 0
  - btn_state = 0, press_pulse = 0
  - toggle regs = 0, blink counters = 0, blink phase = 0
  - led_out = 0
- Reset takes priority over every other event, including mid-debounce, mid-blink and mid-pulse.
- Synchroniser: sync1 <= btn_in, sync2 <= sync1. Normalised level p = (sync2 == ACTIVE_LEVEL).
- Debounce, per channel; counter width = clog2(DEBOUNCE):
  - If p == btn_state: cnt <= 0.
  - Else if cnt == DEBOUNCE-1: btn_state <= p and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any bounce back to the old level before acceptance restarts the count from 0.
- Latency: btn_in stable from before edge k; btn_state changes at edge k+1+DEBOUNCE.
- press_pulse:
  - Registered. High for exactly the first cycle in which btn_state is 1 after being 0.
  - No pulse on release.
  - Channels are independent; simultaneous presses give simultaneous pulses.
- Toggle reg:
  - Flips at the same edge that press_pulse is set, only when mode==01.
  - Holds its value in all other modes and across mode changes.
- Blink counter and phase, per channel:
  - At the edge that sets press_pulse: cnt <= 0, phase <= 1.
  - Otherwise, while btn_state==1: cnt increments; at cnt==BLINK_HALF-1 it wraps to 0 and phase flips.
  - While btn_state==0: cnt <= 0, phase <= 0.
- led_out, registered, one edge after its source:
  - FOLLOW: led_out <= btn_state
  - TOGGLE: led_out <= toggle
  - BLINK: led_out <= btn_state & phase
  - OFF: led_out <= 0
- Mode change: takes effect on led_out at the edge after the new mode is sampled. Internal state is not disturbed.
- Worked latency with DEBOUNCE=4: clean press sampled at edge 0 → btn_state and press_pulse high after edge 5 → FOLLOW led_out high after edge 6.

Test Plan (CHANNELS=4, DEBOUNCE=4, BLINK_HALF=3, ACTIVE_LEVEL=1):
- Reset, then btn_in=0 for 20 cycles → all outputs 0; assert reset for 1 cycle mid-debounce of ch0 → counter cleared, btn_state[0] never rises.
- FOLLOW mode, btn_in[0] 0→1 clean before edge 0 → btn_state[0]=1 and press_pulse[0]=1 after edge 5; press_pulse[0]=0 after edge 6; led_out[0]=1 after edge 6; release mirrors this with no pulse.
- Bounce on btn_in[1]: toggle every 3 cycles for 30 cycles, then hold 1 → no btn_state[1] change during the bounce; exactly one press_pulse[1], DEBOUNCE+2 edges after the last edge.
- TOGGLE mode, three clean presses on ch2 → led_out[2] sequence 1,0,1; switch to FOLLOW and back → toggle value retained (1).
- BLINK mode, hold ch3 for 20 cycles → led_out[3] pattern 1,1,1,0,0,0,1,... starting one edge after press_pulse; release → led_out[3]=0 one edge after btn_state[3] falls.
- ACTIVE_LEVEL=0 build, plus simultaneous presses on all channels in OFF mode → btn_state=4'hF and press_pulse=4'hF on the same cycle; led_out stays 4'h0.
